// File: rtl/seg7_display_arbiter_if.sv
// Producer-side bundle for the shared 4-digit 7-segment display:
// two BCD request channels in, one-hot grant and pad drive out.
interface seg7_display_arbiter_if;
  logic        req0;
  logic [15:0] bcd0;
  logic [3:0]  dp0;
  logic        req1;
  logic [15:0] bcd1;
  logic [3:0]  dp1;
  logic [1:0]  gnt;
  logic [7:0]  SEG;
  logic [3:0]  DIGIT;

  modport master (
    output req0, bcd0, dp0, req1, bcd1, dp1,
    input  gnt, SEG, DIGIT
  );

  modport slave (
    input  req0, bcd0, dp0, req1, bcd1, dp1,
    output gnt, SEG, DIGIT
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter with minimum hold time between two BCD producers,
// plus the 4-digit scan (with anti-ghosting blank) and BCD-to-segment encode.
module seg7_display_arbiter #(
  parameter int SCAN_DIV = 12000,
  parameter int BLANK    = 120,
  parameter int HOLD     = 12000000
) (
  input  logic                   clk,
  input  logic                   rst,
  seg7_display_arbiter_if.slave  bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_V  = SW'(BLANK);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [1:0]      posn_q, posn_d;
  logic [3:0]      snap_nib_q, snap_nib_d;
  logic            snap_dp_q, snap_dp_d;
  logic            snap_valid_q, snap_valid_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      digit_q, digit_d;

  logic [15:0]     sel_bcd;
  logic [3:0]      sel_dp;

  // BCD nibble to active-low {g,f,e,d,c,b,a}; non-decimal codes are dark
  function automatic logic [6:0] encode(input logic [3:0] nib);
    case (nib)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = 7'h7F;
    endcase
  endfunction

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      hold_cnt_q   <= '0;
      slot_cnt_q   <= '0;
      posn_q       <= '0;
      snap_nib_q   <= '0;
      snap_dp_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      seg_q        <= '1;
      digit_q      <= '1;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_cnt_q   <= hold_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      posn_q       <= posn_d;
      snap_nib_q   <= snap_nib_d;
      snap_dp_q    <= snap_dp_d;
      snap_valid_q <= snap_valid_d;
      seg_q        <= seg_d;
      digit_q      <= digit_d;
    end
  end

  // Arbiter next state, round-robin pointer and hold counter
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? G0 : G1;
        else if (bus.req0)        state_d = G0;
        else if (bus.req1)        state_d = G1;
      end
      G0: begin
        if (!bus.req0)                                state_d = bus.req1 ? G1 : IDLE;
        else if (bus.req1 && hold_cnt_q == HOLD_MAX)  state_d = G1;
      end
      G1: begin
        if (!bus.req1)                                state_d = bus.req0 ? G0 : IDLE;
        else if (bus.req0 && hold_cnt_q == HOLD_MAX)  state_d = G0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == G0)      last_d = 1'b0;
      else if (state_d == G1) last_d = 1'b1;
    end else if (state_q != IDLE && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
  end

  // Scan counters, slot-start snapshot and registered pad drive.
  // At slot_cnt == 0 the live data is both captured and encoded, so the
  // first cycle of a slot already uses the new snapshot (matters for BLANK=0).
  always_comb begin
    sel_bcd      = (state_q == G1) ? bus.bcd1 : bus.bcd0;
    sel_dp       = (state_q == G1) ? bus.dp1  : bus.dp0;

    slot_cnt_d   = (slot_cnt_q == SLOT_MAX) ? '0 : slot_cnt_q + SW'(1);
    posn_d       = (slot_cnt_q == SLOT_MAX) ? posn_q + 2'd1 : posn_q;

    snap_nib_d   = snap_nib_q;
    snap_dp_d    = snap_dp_q;
    snap_valid_d = snap_valid_q;
    if (slot_cnt_q == '0) begin
      snap_nib_d   = sel_bcd[{posn_q, 2'b00} +: 4];
      snap_dp_d    = sel_dp[posn_q];
      snap_valid_d = (state_q != IDLE);
    end

    seg_d   = snap_valid_d ? {~snap_dp_d, encode(snap_nib_d)} : 8'hFF;
    digit_d = (!snap_valid_d || slot_cnt_q < BLANK_V) ? 4'hF : ~(4'b0001 << posn_q);
  end

  assign bus.gnt   = {state_q == G1, state_q == G0};
  assign bus.SEG   = seg_q;
  assign bus.DIGIT = digit_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench: cycle model of ownership and scan timing compared on
// every cycle, plus directed scenarios with literal expectations.
module tb_seg7_display_arbiter;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int HD = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_display_arbiter_if bus();

  seg7_display_arbiter #(.SCAN_DIV(SD), .BLANK(BL), .HOLD(HD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for a given DIGIT pattern; a timeout is a failed comparison.
  task automatic wait_digit(input string name, input logic [3:0] pat, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.DIGIT === pat) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] model_seg(input logic [3:0] n, input logic dp);
    logic [7:0] s;
    case (n)
      4'd0: s = 8'hC0; 4'd1: s = 8'hF9; 4'd2: s = 8'hA4; 4'd3: s = 8'hB0;
      4'd4: s = 8'h99; 4'd5: s = 8'h92; 4'd6: s = 8'h82; 4'd7: s = 8'hF8;
      4'd8: s = 8'h80; 4'd9: s = 8'h90; default: s = 8'hFF;
    endcase
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

  int         m_owner;   // 0 none, 1 channel 0, 2 channel 1
  int         m_last;
  int         m_held;    // cycles the current owner has shown on gnt
  int         m_t;       // cycles since reset release
  bit         m_live = 1'b0;
  logic       m_valid;
  logic [3:0] m_nib;
  logic       m_dp;
  logic [7:0] m_seg;
  logic [3:0] m_dig;
  int         off, pos, want;
  logic       r0, r1, mine, other;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_last = 1; m_held = 0; m_t = 0;
      m_valid = 1'b0; m_seg = 8'hFF; m_dig = 4'hF; m_live = 1'b1;
    end else begin
      r0  = bus.req0;
      r1  = bus.req1;
      off = m_t % SD;
      pos = (m_t / SD) % 4;
      if (off == 0) begin
        m_valid = (m_owner != 0);
        if (m_owner == 2) begin
          m_nib = bus.bcd1[pos*4 +: 4]; m_dp = bus.dp1[pos];
        end else begin
          m_nib = bus.bcd0[pos*4 +: 4]; m_dp = bus.dp0[pos];
        end
      end
      m_seg = m_valid ? model_seg(m_nib, m_dp) : 8'hFF;
      m_dig = (m_valid && off >= BL) ? ~(4'b0001 << pos) : 4'hF;
      m_t++;

      want = m_owner;
      if (m_owner == 0) begin
        if (r0 && r1)  want = (m_last == 0) ? 2 : 1;
        else if (r0)   want = 1;
        else if (r1)   want = 2;
      end else begin
        mine  = (m_owner == 1) ? r0 : r1;
        other = (m_owner == 1) ? r1 : r0;
        if (!mine)                      want = other ? 3 - m_owner : 0;
        else if (other && m_held >= HD) want = 3 - m_owner;
      end
      if (want != m_owner) begin
        m_held = (want == 0) ? 0 : 1;
        if (want != 0) m_last = want - 1;
      end else if (m_owner != 0) begin
        m_held++;
      end
      m_owner = want;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("model_gnt", 32'(bus.gnt), (m_owner == 1) ? 32'd1 : (m_owner == 2) ? 32'd2 : 32'd0);
      check("model_digit", 32'(bus.DIGIT), 32'(m_dig));
      if (m_dig != 4'hF || !m_valid)
        check("model_seg", 32'(bus.SEG), 32'(m_seg));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] t2_pats [3] = '{4'b1101, 4'b1011, 4'b0111};
  logic [7:0] t2_segs [3] = '{8'hB0, 8'h24, 8'hF9};

  initial begin
    int n;
    bus.req0 = 1'b0; bus.bcd0 = '0; bus.dp0 = '0;
    bus.req1 = 1'b0; bus.bcd1 = '0; bus.dp1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (64) begin
      @(negedge clk);
      check("idle_gnt", 32'(bus.gnt), 32'd0);
      check("idle_digit", 32'(bus.DIGIT), 32'hF);
      check("idle_seg", 32'(bus.SEG), 32'hFF);
    end

    // Single channel 0 showing 1234 with dp on the hundreds digit
    bus.bcd0 = 16'h1234; bus.dp0 = 4'b0100; bus.req0 = 1'b1;
    @(negedge clk);
    check("t2_gnt", 32'(bus.gnt), 32'd1);
    wait_digit("t2_wait_units", 4'b1110, 64);
    check("t2_seg_units", 32'(bus.SEG), 32'h99);
    for (int k = 0; k < 3; k++) begin
      wait_digit("t2_wait_blank", 4'hF, 16);
      n = 1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.DIGIT !== 4'hF) break;
        n++;
      end
      check("t2_blank_len", 32'(n), 32'd2);
      check("t2_digit", 32'(bus.DIGIT), 32'(t2_pats[k]));
      check("t2_seg", 32'(bus.SEG), 32'(t2_segs[k]));
    end

    // Contention from reset: alternate every HOLD cycles
    rst = 1'b1; bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    check("t3_first_g0", 32'(bus.gnt), 32'd1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.gnt !== 2'b01) break;
      n++;
    end
    check("t3_hold_g0", 32'(n), 32'd20);
    check("t3_then_g1", 32'(bus.gnt), 32'd2);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.gnt !== 2'b10) break;
      n++;
    end
    check("t3_hold_g1", 32'(n), 32'd20);
    check("t3_back_g0", 32'(bus.gnt), 32'd1);

    // Holder drops early at hold_cnt = 5
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.gnt === 2'b10) begin n = 1; break; end
    end
    check("t4_reach_g1", 32'(n), 32'd1);
    repeat (5) @(negedge clk);
    bus.req1 = 1'b0;
    @(negedge clk);
    check("t4_early_g0", 32'(bus.gnt), 32'd1);

    // Snapshot: a mid-slot change waits for the next units slot
    rst = 1'b1; bus.req0 = 1'b0; bus.bcd0 = 16'h0000; bus.dp0 = 4'b0000;
    @(negedge clk);
    rst = 1'b0; bus.req0 = 1'b1;
    wait_digit("t5_wait_units", 4'b1110, 64);
    check("t5_seg_before", 32'(bus.SEG), 32'hC0);
    bus.bcd0 = 16'h0009;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.DIGIT !== 4'b1110) break;
      check("t5_seg_held", 32'(bus.SEG), 32'hC0);
    end
    wait_digit("t5_wait_next_units", 4'b1110, 64);
    check("t5_seg_after", 32'(bus.SEG), 32'h90);

    // Non-decimal nibble with dp, then reset mid-slot
    bus.bcd0 = 16'h000A; bus.dp0 = 4'b0001;
    wait_digit("t6_wait_tens", 4'b1101, 64);
    wait_digit("t6_wait_units", 4'b1110, 64);
    check("t6_seg_a_dp", 32'(bus.SEG), 32'h7F);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_seg", 32'(bus.SEG), 32'hFF);
    check("t6_rst_digit", 32'(bus.DIGIT), 32'hF);
    check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.DIGIT === 4'b1101) break;
    end
    check("t6_restart_posn", 32'(n), 32'd11);

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the single 4-digit common-anode 7-segment display between two independent BCD producers, such as a free-running counter and a status/message source. It arbitrates ownership with round-robin fairness and a minimum hold time. It also performs the digit scan with an anti-ghosting blank interval and encodes BCD to segment patterns. It sits between the producers and the `seg_*`/`ca*` pads, replacing the scan and encode logic inside each producer.

## Interface
Parameters:
- `SCAN_DIV`, default 12000: clock cycles per digit slot (1 kHz per digit at 12 MHz).
- `BLANK`, default 120: cycles at the start of each slot with all digits disabled. Legal range 0 ≤ BLANK < SCAN_DIV.
- `HOLD`, default 12000000: minimum grant duration in cycles while the other channel is waiting. HOLD ≥ 1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req0` in 1: channel 0 requests the display. Level-sensitive.
- `bcd0` in 16: channel 0 digits, {thousands, hundreds, tens, units}, 4 bits each.
- `dp0` in 4: channel 0 decimal-point enables, bit i goes with digit i (0 = units). Active-high.
- `req1`, `bcd1`, `dp1`: same as channel 0, for channel 1.
- `gnt` out 2: one-hot grant; bit i set means channel i owns the display.
- `SEG` out 8: {dp,g,f,e,d,c,b,a}. Active-low.
- `DIGIT` out 4: {ca1,ca2,ca3,ca4}. Active-low digit enables.

## Operation
Arbiter FSM states:
- IDLE: `gnt` = 00.
- G0: `gnt` = 01.
- G1: `gnt` = 10.
- A 1-bit round-robin pointer `last` records the most recently granted channel.

FSM transitions:
- From IDLE:
  - only req0 → G0.
  - only req1 → G1.
  - both → the channel ≠ `last`.
- From Gi:
  - req_i low → G(other) if req_other is high, else IDLE. This happens immediately, with no hold applied.
  - req_i high and req_other high and `hold_cnt` == HOLD-1 → G(other).
  - otherwise stay.
- `hold_cnt` is 0 on entry to any G state. It increments each cycle in a G state and saturates at HOLD-1.
- `last` updates on every entry to G0/G1.

Scan and encode:
- `slot_cnt` counts 0..SCAN_DIV-1. On wrap it returns to 0 and `posn` (2 bits) increments. `posn` wraps 3→0.
- Slot p maps to:
  - p=0: units, DIGIT 1110.
  - p=1: tens, DIGIT 1101.
  - p=2: hundreds, DIGIT 1011.
  - p=3: thousands, DIGIT 0111.
- At `slot_cnt` == 0, the nibble and dp bit for `posn` are snapshotted from the channel granted in that cycle. Changes to the inputs later in the slot are not shown until the next slot.
- If the FSM is in IDLE at the snapshot, the slot is blank: SEG = FF and DIGIT = 1111 for the whole slot.
- DIGIT = 1111 while `slot_cnt` < BLANK. Otherwise DIGIT carries the pattern for `posn`.
- Encoding (active-low, PGFEDCBA; dp bit 7 = ~dp):
  - 0: C0
  - 1: F9
  - 2: A4
  - 3: B0
  - 4: 99
  - 5: 92
  - 6: 82
  - 7: F8
  - 8: 80
  - 9: 90
  - 10–15: segments off, low 7 bits all 1; dp still honoured.
- The scan never stops. Grant changes do not reset `slot_cnt` or `posn`.

## Timing
- Reset values:
  - FSM = IDLE, `last` = 1, so channel 0 wins the first tie.
  - `gnt` = 00, `hold_cnt` = 0, `slot_cnt` = 0, `posn` = 0.
  - SEG = 8'hFF, DIGIT = 4'b1111.
- Reset applied mid-operation blanks the display and drops the grant on the next edge.
- `gnt` is registered. req sampled high at edge t gives `gnt` at edge t+1. req sampled low gives `gnt` cleared at edge t+1.
- Contended handover: `gnt` stays on the holder for exactly HOLD cycles and then moves at the next edge.
- SEG and DIGIT are registered with 1-cycle latency from `slot_cnt`/`posn`/snapshot. Within a slot, DIGIT goes active at cycle BLANK+1 and is held through cycle SCAN_DIV of that slot.
- With BLANK = 0, DIGIT is never blanked and changes directly between digit patterns.
- Simultaneous drop of req_i and rise of req_other in one cycle: go directly Gi → G(other). There is no IDLE cycle.

## Test plan
Use SCAN_DIV=8, BLANK=2, HOLD=20 for all scenarios.
- Reset then idle: `gnt`=00, DIGIT=1111, SEG=FF for 64 cycles.
- req0=1, bcd0=16'h1234, dp0=0100:
  - `gnt`=01 one cycle after req0.
  - Over one frame, DIGIT/SEG sequence is 1110/99, 1101/B0, 1011/24 (dp on), 0111/F9.
  - DIGIT=1111 for 2 cycles at the start of each slot.
- Both req asserted in the same cycle from reset:
  - G0 first, then G1 after exactly 20 cycles.
  - Then G0 after 20 more cycles, alternating while both stay high.
- Holder drops early: in G1 with req0 waiting, drop req1 at hold_cnt=5 → `gnt`=01 on the next edge.
- Snapshot rule: change bcd0 from 16'h0000 to 16'h0009 at slot_cnt=3 of the units slot → SEG stays C0 for the rest of that slot and shows 90 in the next units slot.
- Nibble A with dp0=0001, then rst pulsed mid-slot:
  - Before reset: units shows SEG=7F.
  - Next edge: SEG=FF, DIGIT=1111, `gnt`=00.
  - Scan restarts at posn 0.
